// File: rtl/exec_stage.sv
// Execute stage: operand select/forwarding, 2-op ALU, conditional execution against a
// {zero, carry} CCR, and a valid/ready output register. Define EXEC_FLUSH_EN to add i_flush.
module exec_stage #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned RD_BITS = 3
) (
  input  logic               i_clk,
  input  logic               i_reset,
`ifdef EXEC_FLUSH_EN
  input  logic               i_flush,
`endif
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [1:0]         i_op,
  input  logic [1:0]         i_cond,
  input  logic               i_ccr_we,
  input  logic [WIDTH-1:0]   i_src_a,
  input  logic [WIDTH-1:0]   i_src_b,
  input  logic [WIDTH-1:0]   i_imm,
  input  logic               i_imm_sel_b,
  input  logic [1:0]         i_fwd_sel_a,
  input  logic [1:0]         i_fwd_sel_b,
  input  logic [WIDTH-1:0]   i_fwd_mem,
  input  logic [WIDTH-1:0]   i_fwd_wb,
  input  logic [WIDTH-1:0]   i_ra_src,
  input  logic [RD_BITS-1:0] i_rd_in,
  input  logic               i_out_ready,
  output logic               o_out_valid,
  output logic [WIDTH-1:0]   o_alu_out,
  output logic [WIDTH-1:0]   o_ra_out,
  output logic [RD_BITS-1:0] o_rd_out,
  output logic               o_wr_en,
  output logic [1:0]         o_ccr
);

  typedef enum logic [1:0] {OpAdd = 2'b00, OpNand = 2'b01, OpSub = 2'b10, OpPassA = 2'b11} op_e;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_alu_out;
  logic [WIDTH-1:0]   r_ra_out;
  logic [RD_BITS-1:0] r_rd_out;
  logic               r_wr_en;
  logic [1:0]         r_ccr;

  logic               w_flush;
  logic               w_accept;
  logic [WIDTH-1:0]   w_b_pre;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_carry_op;
  logic               w_cond_ok;
  logic               w_zero;

`ifdef EXEC_FLUSH_EN
  assign w_flush = i_flush;
`else
  assign w_flush = 1'b0;
`endif

  assign o_in_ready = !r_out_valid || i_out_ready;
  assign w_accept   = i_in_valid && o_in_ready && !w_flush;

  assign w_b_pre = i_imm_sel_b ? i_imm : i_src_b;

  always_comb begin
    w_a = i_src_a;
    unique case (i_fwd_sel_a)
      2'b00: w_a = i_src_a;
      2'b01: w_a = i_fwd_mem;
      2'b10: w_a = i_fwd_wb;
      2'b11: w_a = '0;
      default: w_a = i_src_a;
    endcase
  end

  always_comb begin
    w_b = w_b_pre;
    unique case (i_fwd_sel_b)
      2'b00: w_b = w_b_pre;
      2'b01: w_b = i_fwd_mem;
      2'b10: w_b = i_fwd_wb;
      2'b11: w_b = '0;
      default: w_b = w_b_pre;
    endcase
  end

  // SUB is A + ~B + 1, so carry-out of 1 means no borrow.
  always_comb begin
    w_sum      = '0;
    w_res      = '0;
    w_carry    = r_ccr[0];
    w_carry_op = 1'b0;
    unique case (op_e'(i_op))
      OpAdd: begin
        w_sum      = {1'b0, w_a} + {1'b0, w_b};
        w_res      = w_sum[WIDTH-1:0];
        w_carry    = w_sum[WIDTH];
        w_carry_op = 1'b1;
      end
      OpSub: begin
        w_sum      = {1'b0, w_a} + {1'b0, ~w_b} + {{WIDTH{1'b0}}, 1'b1};
        w_res      = w_sum[WIDTH-1:0];
        w_carry    = w_sum[WIDTH];
        w_carry_op = 1'b1;
      end
      OpNand:  w_res = ~(w_a & w_b);
      OpPassA: w_res = w_a;
      default: w_res = w_a;
    endcase
  end

  assign w_zero = (w_res == '0);

  always_comb begin
    w_cond_ok = 1'b0;
    unique case (i_cond)
      2'b00: w_cond_ok = 1'b1;
      2'b01: w_cond_ok = r_ccr[0];
      2'b10: w_cond_ok = r_ccr[1];
      2'b11: w_cond_ok = 1'b0;
      default: w_cond_ok = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_alu_out   <= '0;
      r_ra_out    <= '0;
      r_rd_out    <= '0;
      r_wr_en     <= 1'b0;
    end else if (w_flush) begin
      r_out_valid <= 1'b0;
      r_wr_en     <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_alu_out   <= w_res;
      r_ra_out    <= i_ra_src;
      r_rd_out    <= i_rd_in;
      r_wr_en     <= w_cond_ok;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ccr <= 2'b00;
    end else if (w_accept && w_cond_ok && i_ccr_we) begin
      r_ccr <= {w_zero, (w_carry_op ? w_carry : r_ccr[0])};
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_alu_out   = r_alu_out;
  assign o_ra_out    = r_ra_out;
  assign o_rd_out    = r_rd_out;
  assign o_wr_en     = r_wr_en;
  assign o_ccr       = r_ccr;

endmodule

// File: tb/tb_exec_stage.sv
// Directed self-checking bench for exec_stage (WIDTH=16, RD_BITS=3).
module tb_exec_stage;

  localparam int unsigned W  = 16;
  localparam int unsigned RB = 3;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [1:0]    cond;
  logic          ccr_we;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic [W-1:0]  imm;
  logic          imm_sel_b;
  logic [1:0]    fwd_sel_a;
  logic [1:0]    fwd_sel_b;
  logic [W-1:0]  fwd_mem;
  logic [W-1:0]  fwd_wb;
  logic [W-1:0]  ra_src;
  logic [RB-1:0] rd_in;
  logic          out_ready;
  logic          out_valid;
  logic [W-1:0]  alu_out;
  logic [W-1:0]  ra_out;
  logic [RB-1:0] rd_out;
  logic          wr_en;
  logic [1:0]    ccr;

  int n_checks;
  int n_errors;

  exec_stage #(.WIDTH(W), .RD_BITS(RB)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
`ifdef EXEC_FLUSH_EN
    .i_flush     (flush),
`endif
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_op        (op),
    .i_cond      (cond),
    .i_ccr_we    (ccr_we),
    .i_src_a     (src_a),
    .i_src_b     (src_b),
    .i_imm       (imm),
    .i_imm_sel_b (imm_sel_b),
    .i_fwd_sel_a (fwd_sel_a),
    .i_fwd_sel_b (fwd_sel_b),
    .i_fwd_mem   (fwd_mem),
    .i_fwd_wb    (fwd_wb),
    .i_ra_src    (ra_src),
    .i_rd_in     (rd_in),
    .i_out_ready (out_ready),
    .o_out_valid (out_valid),
    .o_alu_out   (alu_out),
    .o_ra_out    (ra_out),
    .o_rd_out    (rd_out),
    .o_wr_en     (wr_en),
    .o_ccr       (ccr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [1:0] c, input logic we,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    op       = o;
    cond     = c;
    ccr_we   = we;
    src_a    = a;
    src_b    = b;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    op        = 2'b00;
    cond      = 2'b00;
    ccr_we    = 1'b0;
    src_a     = '0;
    src_b     = '0;
    imm       = '0;
    imm_sel_b = 1'b0;
    fwd_sel_a = 2'b00;
    fwd_sel_b = 2'b00;
    fwd_mem   = '0;
    fwd_wb    = '0;
    ra_src    = '0;
    rd_in     = '0;
    out_ready = 1'b1;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_ccr", ccr, 0);
    check("rst_alu", alu_out, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    step();

    // 0xFFFF + 1 wraps to zero with carry out
    ra_src = 16'h0042; rd_in = 3'd6;
    issue(2'b00, 2'b00, 1'b1, 16'hFFFF, 16'h0001);
    step();
    check("add_wrap_alu", alu_out, 16'h0000);
    check("add_wrap_wr", wr_en, 1);
    check("add_wrap_ccr", ccr, 2'b11);
    check("add_wrap_valid", out_valid, 1);
    check("add_wrap_ra", ra_out, 16'h0042);
    check("add_wrap_rd", rd_out, 3'd6);

    issue(2'b00, 2'b00, 1'b1, 16'h0001, 16'h0001);
    step();
    check("add_nc_ccr", ccr, 2'b00);

    // Back-to-back: SUB cond=carry sees carry set by preceding ADD
    issue(2'b00, 2'b00, 1'b1, 16'hFFFF, 16'h0001);
    step();
    issue(2'b10, 2'b01, 1'b1, 16'h0005, 16'h0003);
    step();
    check("sub_c1_alu", alu_out, 16'h0002);
    check("sub_c1_wr", wr_en, 1);
    check("sub_c1_ccr", ccr, 2'b01);

    issue(2'b00, 2'b00, 1'b1, 16'h0001, 16'h0001);
    step();
    issue(2'b10, 2'b01, 1'b1, 16'h0005, 16'h0003);
    step();
    check("sub_c0_wr", wr_en, 0);
    check("sub_c0_ccr", ccr, 2'b00);
    check("sub_c0_valid", out_valid, 1);

    // NAND updates zero only; carry held
    issue(2'b00, 2'b00, 1'b1, 16'hFFFF, 16'h0001);
    step();
    issue(2'b01, 2'b00, 1'b1, 16'h0000, 16'h0000);
    step();
    check("nand_alu", alu_out, 16'hFFFF);
    check("nand_ccr", ccr, 2'b01);

    // SUB with immediate: 3 - 5 borrows
    imm = 16'h0005; imm_sel_b = 1'b1;
    issue(2'b10, 2'b00, 1'b1, 16'h0003, 16'h0000);
    step();
    check("subi_alu", alu_out, 16'hFFFE);
    check("subi_ccr", ccr, 2'b00);
    imm_sel_b = 1'b0;

    issue(2'b00, 2'b11, 1'b1, 16'hFFFF, 16'h0001);
    step();
    check("never_wr", wr_en, 0);
    check("never_ccr", ccr, 2'b00);

    issue(2'b11, 2'b00, 1'b1, 16'h0000, 16'h0007);
    step();
    check("pass_alu", alu_out, 16'h0000);
    check("pass_ccr", ccr, 2'b10);

    issue(2'b00, 2'b10, 1'b1, 16'h0002, 16'h0003);
    step();
    check("condz_alu", alu_out, 16'h0005);
    check("condz_wr", wr_en, 1);
    check("condz_ccr", ccr, 2'b00);

    // Forwarding muxes
    fwd_mem = 16'h1234; fwd_wb = 16'h0001; fwd_sel_a = 2'b01; fwd_sel_b = 2'b10;
    issue(2'b00, 2'b00, 1'b0, 16'h0AAA, 16'h0BBB);
    step();
    check("fwd_alu", alu_out, 16'h1235);
    fwd_sel_b = 2'b11;
    step();
    check("fwd_zero_alu", alu_out, 16'h1234);
    check("fwd_ccr", ccr, 2'b00);
    fwd_sel_a = 2'b00; fwd_sel_b = 2'b00;

    // Stall for 3 cycles with a pending instruction
    out_ready = 1'b0;
    ra_src = 16'h0099; rd_in = 3'd5;
    issue(2'b00, 2'b00, 1'b1, 16'hFFFF, 16'h0001);
    #1;
    check("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) step();
    check("stall_alu", alu_out, 16'h1234);
    check("stall_ccr", ccr, 2'b00);
    check("stall_valid", out_valid, 1);
    check("stall_in_ready2", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    step();
    check("release_alu", alu_out, 16'h0000);
    check("release_rd", rd_out, 3'd5);
    check("release_ra", ra_out, 16'h0099);
    check("release_ccr", ccr, 2'b11);

    in_valid = 1'b0;
    step();
    check("drain_valid", out_valid, 0);

    // Asynchronous reset in the middle of a stall
    issue(2'b00, 2'b00, 1'b1, 16'h0000, 16'h0000);
    step();
    check("pre_rst_ccr", ccr, 2'b10);
    out_ready = 1'b0;
    issue(2'b00, 2'b00, 1'b1, 16'h0003, 16'h0004);
    step();
    check("pre_rst_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_ccr", ccr, 2'b00);
    check("async_rst_wr", wr_en, 0);
    check("async_rst_in_ready", in_ready, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    reset = 1'b0;
    step();

`ifdef EXEC_FLUSH_EN
    issue(2'b00, 2'b00, 1'b1, 16'h0000, 16'h0000);
    step();
    check("fl_pre_ccr", ccr, 2'b10);
    flush = 1'b1;
    issue(2'b00, 2'b00, 1'b1, 16'hFFFF, 16'h0001);
    step();
    check("flush_valid", out_valid, 0);
    check("flush_wr", wr_en, 0);
    check("flush_ccr", ccr, 2'b10);
    flush = 1'b0;
    in_valid = 1'b0;
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
